calc_display_ctrl: RTL and testbench

CALC_DISPLAY_CTRL -- requirements
Module: calc_display_ctrl

---
 rtl/calc_display_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_calc_display_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/calc_display_ctrl.sv
// calc_display_ctrl: 8-bit add/subtract calculator with a sequential
// double-dabble binary-to-BCD converter and a 4-digit multiplexed display
// scanner. Digit slot 0 shows the sign (A = minus, F = blank), and slots 1..3
// show the ones, tens and hundreds digits.
module calc_display_ctrl #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       sel,
  input  logic [7:0] SW_A,
  input  logic [7:0] SW_B,
  output logic       busy,
  output logic       done,
  output logic [3:0] an,
  output logic [3:0] digit_code
);

  localparam int            PW     = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_CONV = 2'd2,
    S_LOAD = 2'd3
  } state_t;

  // Double-dabble correction: add 3 to each BCD nibble that is 5 or more
  function automatic logic [11:0] dd_adjust(input logic [11:0] bcd);
    logic [11:0] res;
    res = bcd;
    for (int n = 0; n < 3; n++) begin
      if (bcd[n*4 +: 4] >= 4'd5) begin
        res[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
      end else begin
        res[n*4 +: 4] = bcd[n*4 +: 4];
      end
    end
    return res;
  endfunction

  state_t        r_state;
  logic [7:0]    r_a;
  logic [7:0]    r_b;
  logic          r_sel;
  logic [8:0]    r_bin;
  logic [11:0]   r_bcd;
  logic          r_neg;
  logic [3:0]    r_cnt;
  logic          r_busy;
  logic          r_done;
  logic [3:0]    r_disp_h;
  logic [3:0]    r_disp_t;
  logic [3:0]    r_disp_o;
  logic [3:0]    r_disp_s;
  logic [PW-1:0] r_presc;
  logic [1:0]    r_idx;
  logic [3:0]    r_an;
  logic [3:0]    r_code;

  logic [8:0]    w_mag;
  logic          w_neg;
  logic [11:0]   w_adj;
  logic          w_wrap;
  logic [1:0]    w_idx_next;
  logic [3:0]    w_an_next;
  logic [3:0]    w_code_next;

  assign w_adj = dd_adjust(r_bcd);

  // Magnitude and sign of the captured operation; A<B cannot give zero
  always_comb begin
    w_mag = 9'd0;
    w_neg = 1'b0;
    if (!r_sel) begin
      w_mag = {1'b0, r_a} + {1'b0, r_b};
      w_neg = 1'b0;
    end else if (r_a >= r_b) begin
      w_mag = {1'b0, r_a} - {1'b0, r_b};
      w_neg = 1'b0;
    end else begin
      w_mag = {1'b0, r_b} - {1'b0, r_a};
      w_neg = 1'b1;
    end
  end

  // Calculation FSM: capture, compute, 9 shift steps of conversion, load display
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= 8'd0;
      r_b      <= 8'd0;
      r_sel    <= 1'b0;
      r_bin    <= 9'd0;
      r_bcd    <= 12'd0;
      r_neg    <= 1'b0;
      r_cnt    <= 4'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_disp_h <= 4'd0;
      r_disp_t <= 4'd0;
      r_disp_o <= 4'd0;
      r_disp_s <= 4'hF;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= SW_A;
            r_b     <= SW_B;
            r_sel   <= sel;
            r_busy  <= 1'b1;
            r_state <= S_CALC;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          r_bin   <= w_mag;
          r_neg   <= w_neg;
          r_bcd   <= 12'd0;
          r_cnt   <= 4'd0;
          r_state <= S_CONV;
        end
        S_CONV: begin
          r_bcd <= {w_adj[10:0], r_bin[8]};
          r_bin <= {r_bin[7:0], 1'b0};
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == 4'd8) begin
            r_state <= S_LOAD;
          end else begin
            r_state <= S_CONV;
          end
        end
        S_LOAD: begin
          r_disp_h <= r_bcd[11:8];
          r_disp_t <= r_bcd[7:4];
          r_disp_o <= r_bcd[3:0];
          r_disp_s <= r_neg ? 4'hA : 4'hF;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign w_wrap     = (r_presc == P_LAST);
  assign w_idx_next = w_wrap ? (r_idx + 2'd1) : r_idx;

  // Digit enable and code for the slot that will be active after this edge
  always_comb begin
    w_an_next   = 4'b1110;
    w_code_next = r_disp_s;
    case (w_idx_next)
      2'd0: begin
        w_an_next   = 4'b1110;
        w_code_next = r_disp_s;
      end
      2'd1: begin
        w_an_next   = 4'b1101;
        w_code_next = r_disp_o;
      end
      2'd2: begin
        w_an_next   = 4'b1011;
        w_code_next = r_disp_t;
      end
      2'd3: begin
        w_an_next   = 4'b0111;
        w_code_next = r_disp_h;
      end
      default: begin
        w_an_next   = 4'b1111;
        w_code_next = 4'hF;
      end
    endcase
  end

  // Free-running scan prescaler, digit index and registered display outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_idx   <= 2'd0;
      r_an    <= 4'b1110;
      r_code  <= 4'hF;
    end else begin
      r_presc <= w_wrap ? '0 : (r_presc + {{(PW-1){1'b0}}, 1'b1});
      r_idx   <= w_idx_next;
      r_an    <= w_an_next;
      r_code  <= w_code_next;
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign an         = r_an;
  assign digit_code = r_code;

endmodule

// File: tb/tb_calc_display_ctrl.sv
// Directed self-checking bench for calc_display_ctrl with SCAN_DIV=4.
module tb_calc_display_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sel;
  logic [7:0] SW_A;
  logic [7:0] SW_B;
  logic       busy;
  logic       done;
  logic [3:0] an;
  logic [3:0] digit_code;

  int n_asserts = 0;
  int n_fails   = 0;
  int lat;
  int cnt;

  calc_display_ctrl #(.SCAN_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sel        (sel),
    .SW_A       (SW_A),
    .SW_B       (SW_B),
    .busy       (busy),
    .done       (done),
    .an         (an),
    .digit_code (digit_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply a one-cycle start pulse; returns at the negedge after the start edge
  task automatic do_start(input logic [7:0] a, input logic [7:0] b, input logic s);
    SW_A  = a;
    SW_B  = b;
    sel   = s;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Wait for the first done pulse; returns its negedge count, or -1 on timeout
  task automatic wait_done(output int l);
    l = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        l = i;
        break;
      end
    end
  endtask

  // Count done pulses over n cycles
  task automatic count_done(input int n, output int c);
    c = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done) c++;
    end
  endtask

  // Capture one full scan rotation and compare every slot
  task automatic check_disp(input string tag, input logic [3:0] h, input logic [3:0] t,
                            input logic [3:0] o, input logic [3:0] s);
    logic [3:0] cap [4];
    logic [3:0] seen;
    seen = 4'b0000;
    for (int k = 0; k < 4; k++) cap[k] = 4'h0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      case (an)
        4'b1110: begin cap[0] = digit_code; seen[0] = 1'b1; end
        4'b1101: begin cap[1] = digit_code; seen[1] = 1'b1; end
        4'b1011: begin cap[2] = digit_code; seen[2] = 1'b1; end
        4'b0111: begin cap[3] = digit_code; seen[3] = 1'b1; end
        default: seen = seen;
      endcase
    end
    chk({tag, "_slots"}, {12'd0, seen}, 16'h000F);
    chk({tag, "_sign"},  {12'd0, cap[0]}, {12'd0, s});
    chk({tag, "_ones"},  {12'd0, cap[1]}, {12'd0, o});
    chk({tag, "_tens"},  {12'd0, cap[2]}, {12'd0, t});
    chk({tag, "_hund"},  {12'd0, cap[3]}, {12'd0, h});
  endtask

  // Full calculation: start, latency 11, busy profile, displayed digits
  task automatic run_calc(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic s, input logic [3:0] h, input logic [3:0] t,
                          input logic [3:0] o, input logic [3:0] sg);
    int l;
    do_start(a, b, s);
    chk({tag, "_busy1"}, {15'd0, busy}, 16'd1);
    wait_done(l);
    chk({tag, "_lat"}, 16'(l), 16'd11);
    chk({tag, "_busy0"}, {15'd0, busy}, 16'd0);
    check_disp(tag, h, t, o, sg);
  endtask

  initial begin
    logic [3:0] exp_an;
    logic [3:0] exp_code;
    rst   = 1'b1;
    start = 1'b0;
    sel   = 1'b0;
    SW_A  = 8'd0;
    SW_B  = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, done}, 16'd0);
    chk("rst_an",   {12'd0, an}, 16'h000E);
    chk("rst_code", {12'd0, digit_code}, 16'h000F);

    // Scan order from reset: each slot held for 4 cycles, blank sign, zero digits
    for (int j = 0; j < 20; j++) begin
      if (j > 0) @(negedge clk);
      case ((j / 4) % 4)
        0:       begin exp_an = 4'b1110; exp_code = 4'hF; end
        1:       begin exp_an = 4'b1101; exp_code = 4'h0; end
        2:       begin exp_an = 4'b1011; exp_code = 4'h0; end
        default: begin exp_an = 4'b0111; exp_code = 4'h0; end
      endcase
      chk($sformatf("scan_an_%0d", j),   {12'd0, an}, {12'd0, exp_an});
      chk($sformatf("scan_code_%0d", j), {12'd0, digit_code}, {12'd0, exp_code});
    end

    // Main function patterns
    run_calc("add",   8'd200, 8'd100, 1'b0, 4'd3, 4'd0, 4'd0, 4'hF);
    run_calc("neg",   8'd5,   8'd20,  1'b1, 4'd0, 4'd1, 4'd5, 4'hA);
    run_calc("max",   8'd255, 8'd255, 1'b0, 4'd5, 4'd1, 4'd0, 4'hF);
    run_calc("subp",  8'd200, 8'd13,  1'b1, 4'd1, 4'd8, 4'd7, 4'hF);
    run_calc("zsub",  8'd7,   8'd7,   1'b1, 4'd0, 4'd0, 4'd0, 4'hF);
    run_calc("zadd",  8'd0,   8'd0,   1'b0, 4'd0, 4'd0, 4'd0, 4'hF);

    // Second start during CONV must be ignored; done comes 7 cycles after it
    do_start(8'd200, 8'd100, 1'b0);
    repeat (3) @(negedge clk);
    SW_A  = 8'd1;
    SW_B  = 8'd2;
    sel   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(lat);
    chk("ign_lat", 16'(lat), 16'd7);
    count_done(14, cnt);
    chk("ign_extra_done", 16'(cnt), 16'd0);
    check_disp("ign", 4'd3, 4'd0, 4'd0, 4'hF);

    // Reset at edge k+5 aborts the calculation and clears the display
    do_start(8'd255, 8'd255, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", {15'd0, busy}, 16'd0);
    chk("abort_done", {15'd0, done}, 16'd0);
    chk("abort_an",   {12'd0, an}, 16'h000E);
    chk("abort_code", {12'd0, digit_code}, 16'h000F);
    count_done(15, cnt);
    chk("abort_no_done", 16'(cnt), 16'd0);
    check_disp("abort", 4'd0, 4'd0, 4'd0, 4'hF);
    run_calc("after", 8'd5, 8'd20, 1'b1, 4'd0, 4'd1, 4'd5, 4'hA);

    // Start accepted in the done cycle
    do_start(8'd99, 8'd1, 1'b0);
    wait_done(lat);
    chk("b2b_lat1", 16'(lat), 16'd11);
    do_start(8'd123, 8'd45, 1'b1);
    chk("b2b_busy", {15'd0, busy}, 16'd1);
    wait_done(lat);
    chk("b2b_lat2", 16'(lat), 16'd11);
    check_disp("b2b", 4'd0, 4'd7, 4'd8, 4'hF);

    // Reset wins over start in the same cycle
    SW_A  = 8'd10;
    SW_B  = 8'd10;
    sel   = 1'b0;
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk("prio_busy", {15'd0, busy}, 16'd0);
    count_done(14, cnt);
    chk("prio_no_done", 16'(cnt), 16'd0);
    check_disp("prio", 4'd0, 4'd0, 4'd0, 4'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
